// File: rtl/lif_pkg.sv
// Shared definitions for the spike rate decoder.
//   state_t        : decoder FSM state (IDLE / COUNT)
//   CNT_W_DEF      : default spike count width
//   WIN_W_DEF      : default window length width
//   NO_SPIKE_LAT   : latency reported by a channel that stayed silent for a
//                    whole window (all ones, truncated to WIN_W by the user)
package lif_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 8;

    localparam logic [31:0] NO_SPIKE_LAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/spike_channel_counter.sv
// One spike channel: saturating spike counter plus its result register, and
// (with SPIKE_LATENCY_EN defined) first-spike latency capture.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   active      : counting enabled this cycle
//   spike       : spike level of this channel
//   win_end     : this cycle is the last cycle of the window
//   win_cnt     : window position (SPIKE_LATENCY_EN only)
//   lat_res     : latched first-spike latency (SPIKE_LATENCY_EN only)
//   count_res   : latched spike count of the last completed window
module spike_channel_counter #(
    parameter int CNT_W = 8
`ifdef SPIKE_LATENCY_EN
    ,
    parameter int WIN_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             spike,
    input  logic             win_end,
`ifdef SPIKE_LATENCY_EN
    input  logic [WIN_W-1:0] win_cnt,
    output logic [WIN_W-1:0] lat_res,
`endif
    output logic [CNT_W-1:0] count_res
);

    logic [CNT_W-1:0] cnt;

    // Holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             inc);
        return (inc && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // The closing cycle's spike is folded into the latched count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            count_res <= '0;
        end else if (active) begin
            if (win_end) begin
                count_res <= sat_inc(cnt, spike);
                cnt       <= '0;
            end else begin
                cnt <= sat_inc(cnt, spike);
            end
        end
    end

`ifdef SPIKE_LATENCY_EN
    import lif_pkg::*;

    logic [WIN_W-1:0] lat;
    logic             seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat     <= '0;
            seen    <= 1'b0;
            lat_res <= '0;
        end else if (active) begin
            if (win_end) begin
                // A first spike on the closing cycle still counts.
                if (seen)
                    lat_res <= lat;
                else if (spike)
                    lat_res <= win_cnt;
                else
                    lat_res <= WIN_W'(NO_SPIKE_LAT);
                lat  <= '0;
                seen <= 1'b0;
            end else if (spike && !seen) begin
                lat  <= win_cnt;
                seen <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder: counts spikes per channel over a window of
// win_len cycles and presents one result set through a valid/ready handshake.
// Optional feature macro: SPIKE_LATENCY_EN (first-spike latency per channel;
// without it first_lat is constant 0).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   ena         : 1 = decode, 0 = freeze all counters
//   spike_in    : per-channel spike levels
//   win_len     : window length in cycles (0 behaves as 1), sampled at window start
//   sel         : channel presented on rate_out / first_lat (>= NUM_CH gives 0)
//   rate_out    : spike count of channel sel for the last completed window
//   first_lat   : first-spike latency of channel sel
//   rate_valid  : result set available
//   rate_ready  : consumer accepts the result set
//   overrun     : sticky, an unaccepted result set was overwritten
module spike_rate_decoder
    import lif_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WIN_W  = WIN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NUM_CH-1:0] spike_in,
    input  logic [WIN_W-1:0]  win_len,
    input  logic [1:0]        sel,
    output logic [CNT_W-1:0]  rate_out,
    output logic [WIN_W-1:0]  first_lat,
    output logic              rate_valid,
    input  logic              rate_ready,
    output logic              overrun
);

    state_t           state, state_nxt;
    logic             active;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] len_q;
    logic [WIN_W-1:0] eff_len;
    logic             win_end;
    logic             handshake;

    logic [CNT_W-1:0] cnt_res [NUM_CH];
`ifdef SPIKE_LATENCY_EN
    logic [WIN_W-1:0] lat_res [NUM_CH];
`endif

    // Counting follows the state being entered, so the first cycle with
    // ena=1 already counts and spikes during ena=0 are never seen.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ena)  state_nxt = COUNT;
            COUNT:   if (!ena) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign active = (state_nxt == COUNT);

    // On the first window cycle the live win_len is used directly; later
    // cycles use the copy sampled then.
    always_comb begin
        eff_len = len_q;
        if (win_cnt == '0)
            eff_len = (win_len == '0) ? WIN_W'(1) : win_len;
    end

    assign win_end   = active && (win_cnt == eff_len - WIN_W'(1));
    assign handshake = rate_valid && rate_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            win_cnt    <= '0;
            len_q      <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (active) begin
                if (win_cnt == '0)
                    len_q <= eff_len;
                win_cnt <= win_end ? '0 : win_cnt + WIN_W'(1);
            end
            if (win_end)
                rate_valid <= 1'b1;
            else if (handshake)
                rate_valid <= 1'b0;
            // A handshake on the overwrite cycle consumes the old set, so no overrun.
            if (handshake)
                overrun <= 1'b0;
            else if (win_end && rate_valid)
                overrun <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        spike_channel_counter #(
            .CNT_W (CNT_W)
`ifdef SPIKE_LATENCY_EN
            ,
            .WIN_W (WIN_W)
`endif
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .active    (active),
            .spike     (spike_in[g]),
            .win_end   (win_end),
`ifdef SPIKE_LATENCY_EN
            .win_cnt   (win_cnt),
            .lat_res   (lat_res[g]),
`endif
            .count_res (cnt_res[g])
        );
    end

    always_comb begin
        rate_out  = '0;
        first_lat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(sel) == i) begin
                rate_out = cnt_res[i];
`ifdef SPIKE_LATENCY_EN
                first_lat = lat_res[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Testbench for spike_rate_decoder (default parameters NUM_CH=3, CNT_W=8, WIN_W=8).
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [2:0] spike_in;
    logic [7:0] win_len;
    logic [1:0] sel = 2'd0;
    logic [7:0] rate_out;
    logic [7:0] first_lat;
    logic       rate_valid;
    logic       rate_ready;
    logic       overrun;

    spike_rate_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .spike_in   (spike_in),
        .win_len    (win_len),
        .sel        (sel),
        .rate_out   (rate_out),
        .first_lat  (first_lat),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    typedef struct packed {
        logic [2:0][7:0] cnt;
        logic [2:0][7:0] lat;
    } res_t;

    // ---------------- reference model ----------------
    res_t       exp_q[$];
    int         m_pos   = 0;
    int         m_len   = 1;
    logic [7:0] m_cnt [3] = '{8'd0, 8'd0, 8'd0};
    int         m_lat [3] = '{0, 0, 0};
    bit   [2:0] m_seen  = 3'b000;
    bit         m_valid = 1'b0;
    bit         m_ovr   = 1'b0;
    bit         m_zero  = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0; m_len = 1; m_seen = 3'b000;
            for (int c = 0; c < 3; c++) begin m_cnt[c] = 8'd0; m_lat[c] = 0; end
            exp_q.delete();
            m_valid = 1'b0; m_ovr = 1'b0; m_zero = 1'b1;
        end else begin
            bit   hs;
            res_t r;
            hs = m_valid && rate_ready;
            if (hs) begin
                void'(exp_q.pop_front());
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            if (ena) begin
                if (m_pos == 0) m_len = (win_len == 8'd0) ? 1 : int'(win_len);
                for (int c = 0; c < 3; c++) begin
                    if (spike_in[c]) begin
                        if (m_cnt[c] != 8'd255) m_cnt[c] = m_cnt[c] + 8'd1;
                        if (!m_seen[c]) begin m_seen[c] = 1'b1; m_lat[c] = m_pos; end
                    end
                end
                if (m_pos == m_len - 1) begin
                    for (int c = 0; c < 3; c++) begin
                        r.cnt[c] = m_cnt[c];
`ifdef SPIKE_LATENCY_EN
                        r.lat[c] = m_seen[c] ? 8'(m_lat[c]) : 8'd255;
`else
                        r.lat[c] = 8'd0;
`endif
                        m_cnt[c] = 8'd0;
                    end
                    if (m_valid) begin
                        void'(exp_q.pop_front());
                        m_ovr = 1'b1;
                    end
                    exp_q.push_back(r);
                    m_valid = 1'b1;
                    m_zero  = 1'b0;
                    m_seen  = 3'b000;
                    m_pos   = 0;
                end else begin
                    m_pos++;
                end
            end
        end
    end

    // ---------------- output monitor ----------------
    logic [7:0] obs_rate [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] obs_lat  [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
    int         hs_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("rate_valid", 32'(rate_valid), 32'(m_valid));
            check("overrun", 32'(overrun), 32'(m_ovr));
            if (rate_valid && rate_ready) hs_cnt++;
            if (m_valid && exp_q.size() > 0) begin
                res_t e;
                e = exp_q[0];
                for (int s = 3; s >= 0; s--) begin
                    sel = 2'(s);
                    #1;
                    obs_rate[s] = rate_out;
                    obs_lat[s]  = first_lat;
                    check("rate_out", 32'(rate_out), (s < 3) ? 32'(e.cnt[s]) : 32'd0);
                    check("first_lat", 32'(first_lat), (s < 3) ? 32'(e.lat[s]) : 32'd0);
                end
            end else if (m_zero) begin
                for (int s = 3; s >= 0; s--) begin
                    sel = 2'(s);
                    #1;
                    check("rate_out_zero", 32'(rate_out), 32'd0);
                    check("first_lat_zero", 32'(first_lat), 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int h0;
        rst_n = 1'b0; ena = 1'b0; rate_ready = 1'b1; win_len = 8'd4; spike_in = 3'b000;
        step(3);
        check("reset_valid", 32'(rate_valid), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_rate", 32'(rate_out), 32'd0);
        rst_n = 1'b1;
        step(2);

        // win_len=4, ch0 spiking every cycle, always ready
        h0 = hs_cnt;
        spike_in = 3'b001; ena = 1'b1;
        step(20);
        ena = 1'b0;
        step(1);
        check("win4_handshakes", 32'(hs_cnt - h0), 32'd5);
        check("win4_rate_ch0", 32'(obs_rate[0]), 32'd4);
        check("win4_rate_ch1", 32'(obs_rate[1]), 32'd0);

        // spikes while disabled are ignored
        spike_in = 3'b111;
        step(3);
        spike_in = 3'b001; ena = 1'b1;
        step(4);
        ena = 1'b0;
        step(1);
        check("frozen_rate_ch0", 32'(obs_rate[0]), 32'd4);
        check("frozen_rate_ch1", 32'(obs_rate[1]), 32'd0);

        // full-length window reaches the count ceiling
        win_len = 8'hFF; spike_in = 3'b010; ena = 1'b1;
        step(255);
        ena = 1'b0;
        step(2);
        check("win255_rate_ch1", 32'(obs_rate[1]), 32'd255);

        // win_len=0 behaves as a one-cycle window
        win_len = 8'd0; ena = 1'b1;
        step(3);
        ena = 1'b0;
        step(2);
        check("win0_rate_ch1", 32'(obs_rate[1]), 32'd1);
        check("win0_rate_ch0", 32'(obs_rate[0]), 32'd0);

        // two window ends without acceptance
        rate_ready = 1'b0; win_len = 8'd4; spike_in = 3'b001; ena = 1'b1;
        step(4);
        spike_in = 3'b100;
        step(4);
        ena = 1'b0;
        step(1);
        check("ovr_valid", 32'(rate_valid), 32'd1);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_rate_ch2", 32'(obs_rate[2]), 32'd4);
        check("ovr_rate_ch0", 32'(obs_rate[0]), 32'd0);
        rate_ready = 1'b1;
        step(1);
        check("ovr_clr_valid", 32'(rate_valid), 32'd0);
        check("ovr_clr_flag", 32'(overrun), 32'd0);

        // window end coincident with a handshake
        rate_ready = 1'b0; spike_in = 3'b001; ena = 1'b1;
        step(4);
        spike_in = 3'b011;
        step(3);
        rate_ready = 1'b1;
        step(1);
        ena = 1'b0; rate_ready = 1'b0;
        check("coinc_valid", 32'(rate_valid), 32'd1);
        check("coinc_overrun", 32'(overrun), 32'd0);
        step(1);
        check("coinc_rate_ch0", 32'(obs_rate[0]), 32'd4);
        check("coinc_rate_ch1", 32'(obs_rate[1]), 32'd4);

        // reset mid-window after three spikes
        rate_ready = 1'b1; win_len = 8'd8; spike_in = 3'b001; ena = 1'b1;
        step(3);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(rate_valid), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        check("midrst_rate", 32'(rate_out), 32'd0);
        check("midrst_lat", 32'(first_lat), 32'd0);
        win_len = 8'd4;
        step(1);
        rst_n = 1'b1;
        step(4);
        ena = 1'b0;
        step(1);
        check("postrst_rate_ch0", 32'(obs_rate[0]), 32'd4);

        // first-spike latency: ch2 first spikes at window cycle 5
        win_len = 8'd8; spike_in = 3'b000; ena = 1'b1;
        step(5);
        spike_in = 3'b100;
        step(3);
        ena = 1'b0;
        step(1);
        check("lat_rate_ch2", 32'(obs_rate[2]), 32'd3);
`ifdef SPIKE_LATENCY_EN
        check("lat_ch2", 32'(obs_lat[2]), 32'd5);
        check("lat_ch0_silent", 32'(obs_lat[0]), 32'd255);
`else
        check("lat_ch2", 32'(obs_lat[2]), 32'd0);
        check("lat_ch0_silent", 32'(obs_lat[0]), 32'd0);
`endif

        rate_ready = 1'b1;
        step(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
